// File: rtl/clkdiv_pkg.sv
// Shared types and defaults for the multi-channel clock divider.
package clkdiv_pkg;

    localparam int unsigned CLKDIV_CNT_W       = 32;
    localparam int unsigned CLKDIV_DEFAULT_DIV = 25_000_000;

    typedef enum logic {
        MODE_TOGGLE,
        MODE_PULSE
    } clkdiv_mode_t;

    // Channel-select width; never zero so a single-channel build still has a port.
    function automatic int unsigned clkdiv_ch_w(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/multi_clock_div_if.sv
// Control/status bundle between the divider and its consumers.
interface multi_clock_div_if
    import clkdiv_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = CLKDIV_CNT_W
) ();

    localparam int unsigned CH_W = clkdiv_ch_w(NUM_CH);

    logic [NUM_CH-1:0] enable;
    logic [NUM_CH-1:0] mode;
    logic              div_wr;
    logic [CH_W-1:0]   div_ch;
    logic [CNT_W-1:0]  div_value;
    logic              sync_clr;
    logic [NUM_CH-1:0] slow_clock;
    logic [NUM_CH-1:0] tick;

    modport master (
        output enable, mode, div_wr, div_ch, div_value, sync_clr,
        input  slow_clock, tick
    );

    modport slave (
        input  enable, mode, div_wr, div_ch, div_value, sync_clr,
        output slow_clock, tick
    );

endinterface

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, shadow/active divisor and registered tick/slow_clock outputs.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int unsigned CNT_W       = CLKDIV_CNT_W,
    parameter int unsigned DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  clkdiv_mode_t     i_mode,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_wr_value,
    input  logic             i_sync_clr,
    output logic             o_slow_clock,
    output logic             o_tick
);

    localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] r_cnt, r_active, r_shadow;
    logic             r_slow, r_tick;
    clkdiv_mode_t     r_mode;

    logic [CNT_W-1:0] w_cnt_nxt, w_active_nxt, w_shadow_nxt;
    logic             w_slow_nxt, w_tick_nxt;
    clkdiv_mode_t     w_mode_nxt;
    logic             w_run, w_tc;

    assign w_run = i_enable && (r_active != '0);
    // >= rather than == so a divisor shrunk while stopped cannot strand cnt above the terminal value.
    assign w_tc  = (r_cnt >= (r_active - CNT_W'(1)));

    always_comb begin
        w_shadow_nxt = i_wr ? i_wr_value : r_shadow;
        w_cnt_nxt    = r_cnt;
        w_active_nxt = r_active;
        w_slow_nxt   = r_slow;
        w_tick_nxt   = 1'b0;
        w_mode_nxt   = r_mode;
        if (i_sync_clr) begin
            w_cnt_nxt    = '0;
            w_slow_nxt   = 1'b0;
            w_active_nxt = w_shadow_nxt;
        end else if (!w_run) begin
            w_active_nxt = w_shadow_nxt;
        end else if (w_tc) begin
            w_cnt_nxt    = '0;
            w_tick_nxt   = 1'b1;
            w_active_nxt = w_shadow_nxt;
            w_mode_nxt   = i_mode;
            w_slow_nxt   = (i_mode == MODE_PULSE) ? 1'b1 : ~r_slow;
        end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            // Mode latched at the last TC decides whether the high phase ends here.
            if (r_mode == MODE_PULSE) begin
                w_slow_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_active <= RESET_DIV;
            r_shadow <= RESET_DIV;
            r_slow   <= 1'b0;
            r_tick   <= 1'b0;
            r_mode   <= MODE_TOGGLE;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_active <= w_active_nxt;
            r_shadow <= w_shadow_nxt;
            r_slow   <= w_slow_nxt;
            r_tick   <= w_tick_nxt;
            r_mode   <= w_mode_nxt;
        end
    end

    assign o_slow_clock = r_slow;
    assign o_tick       = r_tick;

endmodule

// File: rtl/multi_clock_div.sv
// NUM_CH independent clock dividers off CLOCK_50; top holds only write decode and sync fan-out.
module multi_clock_div
    import clkdiv_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = CLKDIV_CNT_W,
    parameter int unsigned DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    multi_clock_div_if.slave  bus
);

    localparam int unsigned CH_W = clkdiv_ch_w(NUM_CH);

    logic [NUM_CH-1:0] w_wr;
    logic [NUM_CH-1:0] w_slow;
    logic [NUM_CH-1:0] w_tick;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Indices >= NUM_CH match no channel and are dropped.
        assign w_wr[i] = bus.div_wr && (bus.div_ch == CH_W'(i));

        clkdiv_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_channel (
            .i_clk        (CLOCK_50),
            .i_rst_n      (rst_n),
            .i_enable     (bus.enable[i]),
            .i_mode       (clkdiv_mode_t'(bus.mode[i])),
            .i_wr         (w_wr[i]),
            .i_wr_value   (bus.div_value),
            .i_sync_clr   (bus.sync_clr),
            .o_slow_clock (w_slow[i]),
            .o_tick       (w_tick[i])
        );
    end

    assign bus.slow_clock = w_slow;
    assign bus.tick       = w_tick;

endmodule

// File: tb/tb_multi_clock_div.sv
// Directed scenarios with closed-form expectations, then randomized traffic against a channel model.
module tb_multi_clock_div;
    import clkdiv_pkg::*;

    localparam int unsigned NCH  = 4;
    localparam int unsigned CW   = 32;
    localparam int unsigned DDIV = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    multi_clock_div_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

    multi_clock_div #(
        .NUM_CH      (NCH),
        .CNT_W       (CW),
        .DEFAULT_DIV (DDIV)
    ) dut (
        .CLOCK_50 (clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Model: edges elapsed in the current period, divisor in force, pending divisor, outputs.
    int unsigned m_elapsed [NCH];
    int unsigned m_act     [NCH];
    int unsigned m_sh      [NCH];
    bit          m_slow    [NCH];
    bit          m_tick    [NCH];
    bit          m_pulse   [NCH];
    logic [NCH-1:0] exp_tick, exp_slow;

    function automatic void model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            m_elapsed[ch] = 0;
            m_act[ch]     = DDIV;
            m_sh[ch]      = DDIV;
            m_slow[ch]    = 1'b0;
            m_tick[ch]    = 1'b0;
            m_pulse[ch]   = 1'b0;
        end
        exp_tick = '0;
        exp_slow = '0;
    endfunction

    function automatic void model_edge();
        int unsigned sh;
        for (int ch = 0; ch < NCH; ch++) begin
            sh = (bus.div_wr && (int'(bus.div_ch) == ch)) ? bus.div_value : m_sh[ch];
            if (bus.sync_clr) begin
                m_elapsed[ch] = 0;
                m_slow[ch]    = 1'b0;
                m_tick[ch]    = 1'b0;
                m_act[ch]     = sh;
            end else if (!bus.enable[ch] || m_act[ch] == 0) begin
                m_tick[ch] = 1'b0;
                m_act[ch]  = sh;
            end else if (m_elapsed[ch] + 1 >= m_act[ch]) begin
                m_elapsed[ch] = 0;
                m_tick[ch]    = 1'b1;
                m_act[ch]     = sh;
                m_pulse[ch]   = bus.mode[ch];
                m_slow[ch]    = bus.mode[ch] ? 1'b1 : !m_slow[ch];
            end else begin
                m_elapsed[ch] = m_elapsed[ch] + 1;
                m_tick[ch]    = 1'b0;
                if (m_pulse[ch]) m_slow[ch] = 1'b0;
            end
            m_sh[ch]      = sh;
            exp_tick[ch]  = m_tick[ch];
            exp_slow[ch]  = m_slow[ch];
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        rst_n         = 1'b0;
        bus.enable    = '0;
        bus.mode      = '0;
        bus.div_wr    = 1'b0;
        bus.div_ch    = '0;
        bus.div_value = '0;
        bus.sync_clr  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic write_div(input int unsigned ch, input int unsigned value);
        bus.div_wr    = 1'b1;
        bus.div_ch    = 2'(ch);
        bus.div_value = value;
        step();
        bus.div_wr    = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (bus.tick !== '0 || bus.slow_clock !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs tick=%b slow=%b want 0000/0000", bus.tick, bus.slow_clock);
        end
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            step();
            vectors++;
            if (bus.tick !== '0 || bus.slow_clock !== '0) begin
                miscompares++;
                $display("FAIL idle_after_reset k=%0d tick=%b slow=%b want 0", k, bus.tick,
                         bus.slow_clock);
            end
        end
    endtask

    task automatic test_default_toggle();
        apply_reset();
        bus.enable[0] = 1'b1;
        bus.mode[0]   = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            vectors++;
            if (bus.tick[0] !== ((k % 4) == 0) || bus.slow_clock[0] !== ((k / 4) % 2 == 1)) begin
                miscompares++;
                $display("FAIL default_toggle k=%0d tick=%b slow=%b want %b/%b", k, bus.tick[0],
                         bus.slow_clock[0], (k % 4) == 0, (k / 4) % 2 == 1);
            end
        end
    endtask

    task automatic test_pulse_mode();
        write_div(1, 3);
        bus.enable[1] = 1'b1;
        bus.mode[1]   = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            vectors++;
            if (bus.tick[1] !== ((k % 3) == 0) || bus.slow_clock[1] !== ((k % 3) == 0)) begin
                miscompares++;
                $display("FAIL pulse_mode k=%0d tick=%b slow=%b want %b", k, bus.tick[1],
                         bus.slow_clock[1], (k % 3) == 0);
            end
        end
    endtask

    task automatic test_div_write_midperiod();
        bit want;
        apply_reset();
        write_div(0, 10);
        bus.enable[0] = 1'b1;
        bus.mode[0]   = 1'b1;
        bus.div_ch    = 2'd0;
        bus.div_value = 2;
        for (int k = 1; k <= 16; k++) begin
            bus.div_wr = (k == 6);
            step();
            want = (k == 10) || (k > 10 && ((k - 10) % 2) == 0);
            vectors++;
            if (bus.tick[0] !== want) begin
                miscompares++;
                $display("FAIL div_write_midperiod k=%0d tick=%b want %b", k, bus.tick[0], want);
            end
        end
        bus.div_wr = 1'b0;
    endtask

    task automatic test_enable_hold();
        apply_reset();
        write_div(2, 10);
        bus.enable[2] = 1'b1;
        repeat (7) step();
        bus.enable[2] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            vectors++;
            if (bus.tick[2] !== 1'b0 || bus.slow_clock[2] !== 1'b0) begin
                miscompares++;
                $display("FAIL enable_hold k=%0d tick=%b slow=%b want 0/0", k, bus.tick[2],
                         bus.slow_clock[2]);
            end
        end
        bus.enable[2] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            vectors++;
            if (bus.tick[2] !== (k == 3) || bus.slow_clock[2] !== (k == 3)) begin
                miscompares++;
                $display("FAIL enable_resume k=%0d tick=%b slow=%b want %b", k, bus.tick[2],
                         bus.slow_clock[2], k == 3);
            end
        end
    endtask

    task automatic test_sync_clr();
        logic [1:0] wt, ws;
        apply_reset();
        write_div(0, 4);
        write_div(1, 6);
        bus.enable[0] = 1'b1;
        repeat (3) step();
        bus.enable[1] = 1'b1;
        repeat (5) step();
        bus.sync_clr = 1'b1;
        step();
        bus.sync_clr = 1'b0;
        vectors++;
        if (bus.tick[1:0] !== 2'b00 || bus.slow_clock[1:0] !== 2'b00) begin
            miscompares++;
            $display("FAIL sync_clr_clear tick=%b slow=%b want 00/00", bus.tick[1:0],
                     bus.slow_clock[1:0]);
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            wt = {(k % 6) == 0, (k % 4) == 0};
            ws = {(k / 6) % 2 == 1, (k / 4) % 2 == 1};
            vectors++;
            if (bus.tick[1:0] !== wt || bus.slow_clock[1:0] !== ws) begin
                miscompares++;
                $display("FAIL sync_clr_align k=%0d tick=%b slow=%b want %b/%b", k,
                         bus.tick[1:0], bus.slow_clock[1:0], wt, ws);
            end
        end
    endtask

    task automatic test_stop_n1_async_reset();
        int bad;
        apply_reset();
        write_div(3, 0);
        bus.enable[3] = 1'b1;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (bus.tick[3] !== 1'b0 || bus.slow_clock[3] !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL stopped_n0 active_cycles=%0d want 0", bad);
        end
        write_div(3, 1);
        for (int k = 1; k <= 8; k++) begin
            step();
            vectors++;
            if (bus.tick[3] !== 1'b1 || bus.slow_clock[3] !== ((k % 2) == 1)) begin
                miscompares++;
                $display("FAIL n1_toggle k=%0d tick=%b slow=%b want 1/%b", k, bus.tick[3],
                         bus.slow_clock[3], (k % 2) == 1);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.tick !== '0 || bus.slow_clock !== '0) begin
            miscompares++;
            $display("FAIL async_reset tick=%b slow=%b want 0000/0000", bus.tick, bus.slow_clock);
        end
        apply_reset();
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 0; k < 1500; k++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                bus.enable[ch] = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 15) == 0) bus.mode = 4'($urandom_range(0, 15));
            bus.div_wr    = ($urandom_range(0, 7) == 0);
            bus.div_ch    = 2'($urandom_range(0, 3));
            bus.div_value = $urandom_range(0, 6);
            bus.sync_clr  = ($urandom_range(0, 63) == 0);
            step();
            vectors++;
            if (bus.tick !== exp_tick || bus.slow_clock !== exp_slow) begin
                miscompares++;
                $display("FAIL random k=%0d tick=%b slow=%b want %b/%b", k, bus.tick,
                         bus.slow_clock, exp_tick, exp_slow);
            end
        end
        bus.div_wr   = 1'b0;
        bus.sync_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default_toggle();
        test_pulse_mode();
        test_div_write_midperiod();
        test_enable_hold();
        test_sync_clr();
        test_stop_n1_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
